// File: rtl/dwt_pkg.sv
// Shared constants and the round/saturate helper for the wavelet decimation requantiser.
package dwt_pkg;

   localparam int IN_W  = 28;
   localparam int OUT_W = 16;
   localparam int SHIFT = 8;

   // Constants are held at IN_W+1 bits so the rounding add never wraps.
   localparam logic signed [IN_W:0] ROUND_K = (IN_W+1)'(1 << (SHIFT-1));
   localparam logic signed [IN_W:0] OUT_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [IN_W:0] OUT_MIN = (IN_W+1)'(-(1 << (OUT_W-1)));

   // Round half up, shift out the coefficient scale, clamp to the signed output range.
   function automatic logic [OUT_W-1:0] sat_round(input logic [IN_W-1:0] x);
      logic signed [IN_W:0] s;
      logic signed [IN_W:0] y;
      s = $signed({x[IN_W-1], x}) + ROUND_K;
      y = s >>> SHIFT;
      if (y > OUT_MAX) begin
         return OUT_MAX[OUT_W-1:0];
      end else if (y < OUT_MIN) begin
         return OUT_MIN[OUT_W-1:0];
      end else begin
         return y[OUT_W-1:0];
      end
   endfunction

endpackage

// File: rtl/dwt_sfifo.sv
// Small synchronous FIFO. Head word is visible combinationally; a word written
// on one edge becomes readable only after that edge (no write-to-read bypass).
// A write while full is accepted only when a read happens in the same cycle.
module dwt_sfifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_wr,
   input  logic [W-1:0]               i_wr_data,
   input  logic                       i_rd,
   output logic [W-1:0]               o_rd_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_wr_ok;
   logic          w_rd_ok;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_rd_ok   = i_rd && !o_empty;
   assign w_wr_ok   = i_wr && (!o_full || w_rd_ok);

   // Storage array: no reset so it can map to distributed RAM.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= r_level + {{AW{1'b0}}, w_wr_ok} - {{AW{1'b0}}, w_rd_ok};
      end
   end

endmodule

// File: rtl/dwt_decim_requant.sv
// Decimate-by-2, round/saturate and paced replay of one wavelet FIR branch.
// Data widths come from dwt_pkg; buffering, pacing and kept phase are parameters.
module dwt_decim_requant
   import dwt_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP        = 4,
   parameter int KEEP_PHASE = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [IN_W-1:0]               in_data,
   input  logic                          in_flag,
   input  logic                          phase_clr,
   input  logic                          out_en,
   output logic [OUT_W-1:0]              out_data,
   output logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          ovf
);

   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   logic              r_phase;
   logic              r_req_vld;
   logic [OUT_W-1:0]  r_req_data;
   logic [GAP_W-1:0]  r_gap;
   logic [OUT_W-1:0]  r_out_data;
   logic              r_out_ready;
   logic              r_ovf;

   logic              w_phase_eff;
   logic              w_keep;
   logic              w_emit;
   logic              w_full;
   logic              w_empty;
   logic [OUT_W-1:0]  w_head;

   // phase_clr forces the judged phase to 0 for a sample arriving the same cycle.
   assign w_phase_eff = phase_clr ? 1'b0 : r_phase;
   assign w_keep      = in_flag && (w_phase_eff == 1'(KEEP_PHASE));
   assign w_emit      = !w_empty && out_en && (r_gap == '0);

   // Polyphase selector: toggles on every input strobe, kept or dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= in_flag ? ~w_phase_eff : w_phase_eff;
      end
   end

   // Requant stage: one register between the FIR output and the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_vld  <= 1'b0;
         r_req_data <= '0;
      end else begin
         r_req_vld <= w_keep;
         if (w_keep) begin
            r_req_data <= sat_round(in_data);
         end
      end
   end

   dwt_sfifo #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_wr      (r_req_vld),
      .i_wr_data (r_req_data),
      .i_rd      (w_emit),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (fifo_level)
   );

   // Pacing counter: keeps emissions GAP cycles apart; runs even while out_en is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_gap <= '0;
      end else if (w_emit) begin
         r_gap <= GAP_W'(GAP - 1);
      end else if (r_gap != '0) begin
         r_gap <= r_gap - GAP_W'(1);
      end
   end

   // Output strobe and data, data held between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_ready <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_ready <= w_emit;
         if (w_emit) begin
            r_out_data <= w_head;
         end
      end
   end

   // Sticky overflow: a kept sample arrived at a full FIFO with no pop to make room.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (r_req_vld && w_full && !w_emit) begin
         r_ovf <= 1'b1;
      end
   end

   assign out_data  = r_out_data;
   assign out_ready = r_out_ready;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_dwt_decim_requant.sv
// Directed bench for dwt_decim_requant (defaults: FIFO_DEPTH=4, GAP=4, KEEP_PHASE=0).
module tb_dwt_decim_requant;

   logic        clk = 1'b0;
   logic        reset;
   logic [27:0] in_data;
   logic        in_flag;
   logic        phase_clr;
   logic        out_en;
   logic [15:0] out_data;
   logic        out_ready;
   logic [2:0]  fifo_level;
   logic        ovf;

   int n_pass    = 0;
   int n_total   = 0;
   int cyc       = 0;
   int max_level = 0;
   int          ev_cyc[$];
   logic [15:0] ev_data[$];

   always #5 clk = ~clk;

   dwt_decim_requant dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_flag    (in_flag),
      .phase_clr  (phase_clr),
      .out_en     (out_en),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .ovf        (ovf)
   );

   // One clock; outputs observed on the falling edge and strobes logged.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (out_ready) begin
         ev_cyc.push_back(cyc);
         ev_data.push_back(out_data);
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic strobe(input logic [27:0] d, input logic clr);
      in_data   = d;
      in_flag   = 1'b1;
      phase_clr = clr;
      tick();
      in_flag   = 1'b0;
      phase_clr = 1'b0;
   endtask

   task automatic clear_log();
      ev_cyc.delete();
      ev_data.delete();
      max_level = 0;
   endtask

   function automatic logic [15:0] ev_d(input int i);
      if (i < ev_data.size()) return ev_data[i];
      return 16'hxxxx;
   endfunction

   function automatic int ev_gap(input int i);
      if (i >= 1 && i < ev_cyc.size()) return ev_cyc[i] - ev_cyc[i-1];
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $display("check %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   logic [27:0] t3_in  [4] = '{28'h7FFFFFF, 28'h8000000, 28'hFFFFF80, 28'hFFFFF7F};
   logic [15:0] t3_exp [4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};

   initial begin
      reset = 1'b1; in_data = '0; in_flag = 1'b0; phase_clr = 1'b0; out_en = 1'b1;
      idle(3);
      reset = 1'b0;
      tick();
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_out_ready", 32'(out_ready), 32'h0);
      check("rst_level", 32'(fifo_level), 32'h0);
      check("rst_ovf", 32'(ovf), 32'h0);

      // 1: latency, 384 -> 2 (1.5 rounds up); strobe visible in cycle t+3
      clear_log();
      strobe(28'd384, 1'b0);
      check("t1_rdy_t1", 32'(out_ready), 32'h0);
      tick();
      check("t1_rdy_t2", 32'(out_ready), 32'h0);
      check("t1_level_t2", 32'(fifo_level), 32'h1);
      tick();
      check("t1_rdy_t3", 32'(out_ready), 32'h1);
      check("t1_data_t3", 32'(out_data), 32'h2);
      tick();
      check("t1_rdy_t4", 32'(out_ready), 32'h0);
      check("t1_data_hold", 32'(out_data), 32'h2);

      // 2: phase is 1 here; phase_clr on first strobe keeps it, second (odd) dropped
      clear_log();
      strobe(28'h0000100, 1'b1);
      idle(5);
      strobe(28'h0000200, 1'b0);
      idle(10);
      check("t2_count", 32'(ev_data.size()), 32'd1);
      check("t2_data", 32'(ev_d(0)), 32'h0001);

      // 3: saturation and rounding boundaries
      clear_log();
      for (int i = 0; i < 4; i++) begin
         strobe(t3_in[i], 1'b1);
         idle(5);
      end
      idle(5);
      check("t3_count", 32'(ev_data.size()), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("t3_data%0d", i), 32'(ev_d(i)), 32'(t3_exp[i]));

      // 4: strobe every 2 cycles for 40 cycles; kept every 4 -> emission spacing 4
      clear_log();
      for (int i = 0; i < 20; i++) begin
         strobe(28'(i) << 8, (i == 0));
         idle(1);
      end
      idle(8);
      check("t4_count", 32'(ev_data.size()), 32'd10);
      for (int k = 0; k < 10; k++) check($sformatf("t4_data%0d", k), 32'(ev_d(k)), 32'(2 * k));
      for (int k = 1; k < 10; k++) check($sformatf("t4_gap%0d", k), 32'(ev_gap(k)), 32'd4);
      check("t4_level_le1", 32'(max_level <= 1), 32'h1);
      check("t4_ovf", 32'(ovf), 32'h0);

      // 5: stalled output, 6 kept into a 4-deep FIFO -> overflow, then drain
      out_en = 1'b0;
      clear_log();
      for (int j = 0; j < 12; j++) begin
         strobe(28'(100 + j) << 8, (j == 0));
         idle(5);
      end
      check("t5_level_full", 32'(fifo_level), 32'd4);
      check("t5_ovf_set", 32'(ovf), 32'h1);
      check("t5_no_emit", 32'(ev_data.size()), 32'd0);
      out_en = 1'b1;
      idle(30);
      check("t5_count", 32'(ev_data.size()), 32'd4);
      for (int k = 0; k < 4; k++) check($sformatf("t5_data%0d", k), 32'(ev_d(k)), 32'(100 + 2 * k));
      for (int k = 1; k < 4; k++) check($sformatf("t5_gap%0d", k), 32'(ev_gap(k)), 32'd4);
      check("t5_ovf_sticky", 32'(ovf), 32'h1);
      check("t5_level_empty", 32'(fifo_level), 32'd0);

      // 6: reset with level 3 and phase 1 clears everything; next sample is kept
      out_en = 1'b0;
      for (int j = 0; j < 5; j++) strobe(28'(200 + j) << 8, (j == 0));
      idle(3);
      check("t6_level3", 32'(fifo_level), 32'd3);
      reset = 1'b1;
      tick();
      check("t6_rst_data", 32'(out_data), 32'h0);
      check("t6_rst_ready", 32'(out_ready), 32'h0);
      check("t6_rst_level", 32'(fifo_level), 32'h0);
      check("t6_rst_ovf", 32'(ovf), 32'h0);
      reset = 1'b0;
      out_en = 1'b1;
      clear_log();
      strobe(28'd300 << 8, 1'b0);
      idle(6);
      check("t6_count", 32'(ev_data.size()), 32'd1);
      check("t6_data", 32'(ev_d(0)), 32'd300);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
